// File: rtl/vectoring_cordic.sv
// Pipelined circular CORDIC, vectoring mode: (X, Y, Z) -> (K*|v|, ~0, Z + atan2(Y, X)).
// Optional macro CORDIC_GAIN_COMP_EN adds a registered 1/K gain-compensation stage on X.

module vectoring_cordic #(
    parameter int STAGES = 16,
    parameter int IW     = 18
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] X_i,
    input  logic signed [15:0] Y_i,
    input  logic signed [15:0] Z_i,
    output logic signed [15:0] X_O,
    output logic signed [15:0] Y_O,
    output logic signed [15:0] Z_O
);

    localparam int OW = 16;
    localparam int PW = IW + 16;

    typedef logic signed [IW-1:0] xy_t;
    typedef logic signed [OW-1:0] ang_t;

    localparam logic signed [PW-1:0] SAT_HI = PW'(32767);
    localparam logic signed [PW-1:0] SAT_LO = PW'(-32768);

    // atan(2^-i) in binary angle units (32768 = pi).
    function automatic ang_t atan_lut(input int idx);
        case (idx)
            0:       return 16'sd8192;
            1:       return 16'sd4836;
            2:       return 16'sd2555;
            3:       return 16'sd1297;
            4:       return 16'sd651;
            5:       return 16'sd326;
            6:       return 16'sd163;
            7:       return 16'sd81;
            8:       return 16'sd41;
            9:       return 16'sd20;
            10:      return 16'sd10;
            11:      return 16'sd5;
            12:      return 16'sd3;
            13:      return 16'sd1;
            14:      return 16'sd1;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic ang_t sat16(input logic signed [PW-1:0] v);
        if (v > SAT_HI) return SAT_HI[OW-1:0];
        if (v < SAT_LO) return SAT_LO[OW-1:0];
        return v[OW-1:0];
    endfunction

    // Index 0 holds the pre-rotated vector; index i+1 holds the result of micro-rotation i.
    xy_t  x_q [0:STAGES];
    xy_t  y_q [0:STAGES];
    ang_t z_q [0:STAGES];

    xy_t  x_ext, y_ext;
    xy_t  x_pre, y_pre;
    ang_t z_pre;

    // Widen before negating so that -(-32768) stays representable.
    assign x_ext = xy_t'(X_i);
    assign y_ext = xy_t'(Y_i);

    // Left-half-plane vectors are turned by +/-90 degrees into the convergence range.
    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = Z_i;
        if (X_i[15]) begin
            if (!Y_i[15]) begin
                x_pre = y_ext;
                y_pre = -x_ext;
                z_pre = Z_i + 16'sd16384;
            end else begin
                x_pre = -y_ext;
                y_pre = x_ext;
                z_pre = Z_i - 16'sd16384;
            end
        end
    end

    // NOTE: the pipeline is a register array, not a RAM, so clearing every entry on reset is cheap and keeps flushed outputs at zero.
    // NOTE: non-blocking assignments let each stage read the previous stage's value from before this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= STAGES; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                z_q[i] <= '0;
            end
        end else begin
            x_q[0] <= x_pre;
            y_q[0] <= y_pre;
            z_q[0] <= z_pre;
            for (int i = 0; i < STAGES; i++) begin
                if (!y_q[i][IW-1]) begin
                    x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
                    y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
                    z_q[i+1] <= z_q[i] + atan_lut(i);
                end else begin
                    x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
                    y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
                    z_q[i+1] <= z_q[i] - atan_lut(i);
                end
            end
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    // X * 0.60725 (Q2.14), rounded; Y and Z ride along to keep the three outputs aligned.
    localparam logic signed [PW-1:0] GAIN = PW'(9949);
    localparam logic signed [PW-1:0] HALF = PW'(8192);

    logic signed [PW-1:0] x_prod, x_scaled;
    ang_t                 x_gc, y_gc, z_gc;

    assign x_prod   = PW'(x_q[STAGES]) * GAIN;
    assign x_scaled = (x_prod + HALF) >>> 14;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_gc <= '0;
            y_gc <= '0;
            z_gc <= '0;
        end else begin
            x_gc <= sat16(x_scaled);
            y_gc <= y_q[STAGES][OW-1:0];
            z_gc <= z_q[STAGES];
        end
    end

    assign X_O = x_gc;
    assign Y_O = y_gc;
    assign Z_O = z_gc;
`else
    assign X_O = sat16(PW'(x_q[STAGES]));
    assign Y_O = y_q[STAGES][OW-1:0];
    assign Z_O = z_q[STAGES];
`endif

endmodule

// File: tb/tb_vectoring_cordic.sv
// Scoreboard bench for vectoring_cordic: expectations come from floating-point atan2/magnitude.
`timescale 1ns/1ps

module tb_vectoring_cordic;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = 18;
    localparam bit GC  = 1'b1;
`else
    localparam int LAT = 17;
    localparam bit GC  = 1'b0;
`endif

    localparam real PI = 3.14159265358979;

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic signed [15:0] X_i   = '0;
    logic signed [15:0] Y_i   = '0;
    logic signed [15:0] Z_i   = '0;
    logic signed [15:0] X_O, Y_O, Z_O;

    vectoring_cordic #(.STAGES(16), .IW(18)) dut (
        .clk   (clk),
        .reset (reset),
        .X_i   (X_i),
        .Y_i   (Y_i),
        .Z_i   (Z_i),
        .X_O   (X_O),
        .Y_O   (Y_O),
        .Z_O   (Z_O)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        string tag;
        int    due;
        int    ex;
        int    tx;
        int    ez;
        bit    chk_z;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    real  k_gain;

    // circ: compare as 16-bit angles, so +pi and -pi are the same value.
    task automatic check(input string tag, input int got, input int exp, input int tol, input bit circ);
        int d;
        d = got - exp;
        if (circ) d = int'(shortint'(d));
        n_checks++;
        if (d > tol || d < -tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (+/- %0d)", tag, got, exp, tol);
        end
    endtask

    // Drives one vector (call right after a negedge) and queues its ideal result.
    task automatic drive(input string tag, input int x, input int y, input int z, input bit chk_z);
        exp_t e;
        real  mag, kx, ang;
        mag = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        kx  = GC ? mag : mag * k_gain;
        ang = $atan2(real'(y), real'(x)) * 32768.0 / PI;
        e.tag   = tag;
        e.due   = edge_cnt + LAT;
        e.chk_z = chk_z;
        e.ez    = int'(shortint'(z + int'(ang)));
        if (kx > 32767.0) begin
            e.ex = 32767;
            e.tx = 0;
        end else begin
            e.ex = int'(kx);
            e.tx = (int'(kx * 0.001) > 2) ? int'(kx * 0.001) : 2;
        end
        sb.push_back(e);
        X_i = 16'(x);
        Y_i = 16'(y);
        Z_i = 16'(z);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            while (sb.size() > 0 && sb[0].due == edge_cnt) begin
                cur = sb.pop_front();
                check({cur.tag, ".x"}, int'(X_O), cur.ex, cur.tx, 1'b0);
                check({cur.tag, ".y"}, int'(Y_O), 0, 4, 1'b0);
                if (cur.chk_z) check({cur.tag, ".z"}, int'(Z_O), cur.ez, 6, 1'b1);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, ".x"}, int'(X_O), 0, 0, 1'b0);
        check({tag, ".y"}, int'(Y_O), 0, 0, 1'b0);
        check({tag, ".z"}, int'(Z_O), 0, 0, 1'b0);
    endtask

    int vx [10] = '{ 11585, -11585, -11585,  11585, -11585, 16384, 32767, -32768, -32768,      0};
    int vy [10] = '{ 11585,  11585, -11585, -11585,  11585,     0, 32767,      0, -32768, -16384};
    int vz [10] = '{     0,      0,      0,      0,  16384,     0,     0,      0,      0,      0};

    initial begin
        k_gain = 1.0;
        for (int i = 0; i < 16; i++) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

        // Asynchronous reset with non-zero inputs, before any clock edge.
        X_i = 16'sh1234;
        Y_i = -16'sh0567;
        Z_i = 16'sh0ABC;
        #1 reset = 1'b0;
        #1 check_zero("rst_async");
        repeat (3) @(posedge clk);
        #1 check_zero("rst_held");

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            drive("zero", 0, 0, 0, 1'b0);
            @(negedge clk);
        end

        // Isolated vectors, each followed by a zero gap that must stay clean.
        for (int v = 0; v < 4; v++) begin
            drive($sformatf("single%0d", v), vx[v], vy[v], vz[v], 1'b1);
            for (int g = 0; g < 3; g++) begin
                @(negedge clk);
                drive("gap", 0, 0, 0, 1'b0);
            end
            @(negedge clk);
        end

        // Back-to-back streaming of every directed vector.
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 10; v++) begin
                drive($sformatf("dir%0d", v), vx[v], vy[v], vz[v], 1'b1);
                @(negedge clk);
            end
        end

        // Random streaming, moderate-to-large magnitudes in all quadrants.
        for (int n = 0; n < 40; n++) begin
            int rx, ry, rz;
            rx = int'($urandom_range(22000, 8000));
            ry = int'($urandom_range(22000, 8000));
            if ($urandom_range(1, 0) == 1) rx = -rx;
            if ($urandom_range(1, 0) == 1) ry = -ry;
            rz = int'($urandom_range(32767, 0)) - 16384;
            drive($sformatf("rnd%0d", n), rx, ry, rz, 1'b1);
            @(negedge clk);
        end

        // Reset in mid-stream, asserted between clock edges.
        for (int v = 0; v < 6; v++) begin
            drive("pre_rst", vx[v], vy[v], vz[v], 1'b1);
            @(negedge clk);
        end
        #2 reset = 1'b0;
        sb.delete();
        #1 check_zero("rst_mid");
        repeat (2) @(posedge clk);
        #1 check_zero("rst_mid_held");
        @(negedge clk);
        reset = 1'b1;
        drive("post_rst", vx[1], vy[1], vz[1], 1'b1);
        for (int g = 0; g < LAT; g++) begin
            @(negedge clk);
            drive("post_gap", 0, 0, 0, 1'b0);
        end
        @(negedge clk);
        X_i = '0;
        Y_i = '0;
        Z_i = '0;

        repeat (LAT + 3) @(negedge clk);
        check("sb_drain", sb.size(), 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vectoring_cordic.md
Name: vectoring_cordic

Overview:
- 16-stage pipelined circular CORDIC in vectoring mode; one new vector accepted per clock.
- Rotates the input vector (X_i, Y_i) onto the +X axis and accumulates the rotation angle into Z.
- Outputs: magnitude on X_O, residual Y_O ≈ 0, and Z_O = Z_i + atan2(Y_i, X_i).
- Used as the rectangular-to-polar conversion block in the datapath.

Parameters:
- STAGES, 16, number of CORDIC micro-rotation stages (the design is verified only at 16).
- IW, 18, internal X/Y width in bits (2 guard bits over the 16-bit I/O).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- X_i  input  16  signed X, Q2.14 (16384 = 1.0).
- Y_i  input  16  signed Y, Q2.14.
- Z_i  input  16  signed initial angle, binary angle (32768 = π, 16384 = 90°).
- X_O  output  16  signed magnitude, Q2.14.
- Y_O  output  16  signed residual Y, Q2.14.
- Z_O  output  16  signed result angle, binary angle.

Behaviour:
- Reset (reset=0, asynchronous): every pipeline register and X_O/Y_O/Z_O = 0. Release is synchronous to clk.
- Pipeline: no handshake; inputs sampled every rising edge. Latency is exactly 17 cycles (1 pre-rotation stage + 16 iteration stages); throughput is 1 per cycle.
- Pre-rotation stage (registered):
  - X_i ≥ 0: pass through unchanged.
  - X_i < 0, Y_i ≥ 0: X' = Y, Y' = −X, Z' = Z + 16384.
  - X_i < 0, Y_i < 0: X' = −Y, Y' = X, Z' = Z − 16384.
  - Operands are sign-extended to IW bits before negation, so −(−32768) does not overflow.
- Stage i = 0..15:
  - Y ≥ 0: X += Y>>>i, Y −= X>>>i, Z += A[i].
  - Y < 0: X −= Y>>>i, Y += X>>>i, Z −= A[i].
  - Shifts are arithmetic. Both updates use the previous-stage values.
- Arctangent table A[i] (binary angle): 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- Z arithmetic is 16-bit two's complement and wraps modulo 2^16, so ±π wraps naturally.
- Output X: CORDIC gain K ≈ 1.64676 is applied unless the optional feature is enabled. X_O saturates to +32767 if the IW-bit result exceeds the 16-bit range.
- Output Y: Y_O is truncated to 16 bits; it stays within a few LSB of 0.
- Accuracy: Z_O within ±6 LSB of the ideal value; X_O within ±0.1% of ideal.
- X_i = Y_i = 0: X_O = 0 and Y_O = 0. Z_O is deterministic per the algorithm but unspecified and not checked.
- Reset mid-stream: pipeline is flushed to zeros immediately. The first valid output appears 17 cycles after the first edge following release.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined: one extra registered stage multiplies the final X by 9949 (0.60725 in Q2.14), rounds, and shifts right by 14. Latency becomes 18 cycles, and X_O equals the true magnitude.
- Undefined: no compensation stage. Latency is 17 cycles and X_O = K·|v|.
- Y/Z behaviour is identical in both builds (delayed to match latency).

Test Plan:
- Reset: hold reset=0 with non-zero inputs → X_O = Y_O = Z_O = 0. Release reset, apply X_i = Y_i = 0, Z_i = 0 → outputs stay 0.
- Quadrant I: X_i = 0x2D41, Y_i = 0x2D41, Z_i = 0 → after 17 cycles:
  - Z_O ≈ 8192 (0x2000).
  - X_O ≈ 26981 (0x6965), or ≈ 16384 with CORDIC_GAIN_COMP_EN.
  - |Y_O| ≤ 4.
- Quadrant II: X_i = 0xD2BF, Y_i = 0x2D41 → Z_O ≈ 24576 (0x6000), X_O as above.
- Quadrants III and IV:
  - X_i = 0xD2BF, Y_i = 0xD2BF → Z_O ≈ −24576 (0xA000).
  - X_i = 0x2D41, Y_i = 0xD2BF → Z_O ≈ −8192 (0xE000).
  - X_O as above in both cases.
- Back-to-back streaming: change inputs every cycle across the four vectors above → each result appears exactly 17 cycles after its input, with no inter-sample corruption.
- Z offset and wrap: X_i = 0xD2BF, Y_i = 0x2D41, Z_i = 16384 → Z_O ≈ −24576 (wraps through π); X_i = 0x4000, Y_i = 0 → Z_O = 0 ± 6, X_O ≈ 26981.
